masked_cf_pipe: RTL and testbench

Parametrised, pipelined successor of the single-bit PRESENT S-box component-function cell for the 3-share low-latency masked S-box. It evaluates all three quadratic coordinates F, G and H, 27 share-domain cells in total, for LANES independent 4-bit S-box lanes. Stage 1 registers every non-complete cell, which is the glitch barrier. Stage 2 compresses the cells back to 3 output shares per coordinate. The block sits between the affine input layer and the next S-box stage, and it adds a valid/ready handshake with backpressure.

---
 rtl/masked_cf_pipe.sv | 157 +++++++++++++++
 tb/tb_masked_cf_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/masked_cf_pipe.sv
// masked_cf_pipe: two-stage pipelined, 3-share masked evaluation of the quadratic
// PRESENT S-box coordinates F, G and H for LANES independent 4-bit lanes.
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   in_valid_i/in_ready_o   input handshake; a/b/c/d and randomness sampled on acceptance
//   a_i..d_i            3 shares per lane, share s of lane l at bit 3l+s
//   r1_i, r2_i, r3_i    9 ring-refresh bits per lane for F, G, H
//   rs_i                6 extra bits per lane, pair [2y+1:2y] belongs to coordinate y
//   out_valid_o/out_ready_i output handshake
//   f_o, g_o, h_o       3 output shares per lane, same packing as inputs
//   idle_o              both pipeline stages empty
module masked_cf_pipe #(
    parameter int unsigned LANES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3*LANES-1:0]   a_i,
    input  logic [3*LANES-1:0]   b_i,
    input  logic [3*LANES-1:0]   c_i,
    input  logic [3*LANES-1:0]   d_i,
    input  logic [9*LANES-1:0]   r1_i,
    input  logic [9*LANES-1:0]   r2_i,
    input  logic [9*LANES-1:0]   r3_i,
    input  logic [6*LANES-1:0]   rs_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [3*LANES-1:0]   f_o,
    output logic [3*LANES-1:0]   g_o,
    output logic [3*LANES-1:0]   h_o,
    output logic                 idle_o
);

    localparam int unsigned NCell = 27 * LANES;

    // Share index i (of b/c) and j (of d) for cells n = 0..8, cell 0 in the LSBs.
    localparam logic [17:0] PairI = {2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1};
    localparam logic [17:0] PairJ = {2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};

    // One share-domain cell. Only shares i, j and the single linear share are touched,
    // so no cell sees all three share indices before the stage-1 register.
    function automatic logic cell_bit(input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] c, input logic [2:0] d,
                                      input logic [8:0] r, input logic [1:0] rs,
                                      input int y, input int n);
        logic [1:0] pi;
        logic [1:0] pj;
        logic       nl;
        logic       lin;
        logic       rsb;
        int         nn;
        pi = PairI[2*n +: 2];
        pj = PairJ[2*n +: 2];
        nl = b[pi] & d[pj];
        if (y == 2) begin
            nl = nl ^ (c[pi] & d[pj]);
        end
        case (9 * y + n)
            1:       lin = d[1];
            2:       lin = c[2];
            4:       lin = d[2];
            5:       lin = c[0];
            7:       lin = c[1];
            8:       lin = d[0];
            11:      lin = c[2];
            14:      lin = c[0];
            16:      lin = c[1];
            19:      lin = b[2];
            20:      lin = a[1];
            22:      lin = b[0];
            23:      lin = a[2];
            25:      lin = a[0];
            26:      lin = b[1];
            default: lin = 1'b0;
        endcase
        // Each output share sums n mod 3 = 0,1,2, so the rs pair cancels per share.
        case (n % 3)
            0:       rsb = rs[0];
            1:       rsb = rs[1];
            default: rsb = rs[0] ^ rs[1];
        endcase
        nn = (n == 8) ? 0 : n + 1;
        cell_bit = nl ^ lin ^ rsb ^ r[n +: 1] ^ r[nn +: 1];
    endfunction

    logic                 s1_valid_q;
    logic [NCell-1:0]     cell_d, cell_q;
    logic                 out_valid_q;
    logic [3*LANES-1:0]   f_d, f_q, g_d, g_q, h_d, h_q;
    logic                 s1_load, s2_load;

    assign s2_load    = !out_valid_q || out_ready_i;
    assign s1_load    = !s1_valid_q || s2_load;
    assign in_ready_o = s1_load;

    // Stage 1: cell index 27l + 9y + n.
    always_comb begin
        cell_d = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            for (int y = 0; y < 3; y++) begin
                for (int n = 0; n < 9; n++) begin
                    cell_d[27*l + 9*y + n +: 1] = cell_bit(
                        a_i[3*l +: 3], b_i[3*l +: 3], c_i[3*l +: 3], d_i[3*l +: 3],
                        (y == 0) ? r1_i[9*l +: 9] : (y == 1) ? r2_i[9*l +: 9] : r3_i[9*l +: 9],
                        rs_i[6*l + 2*y +: 2], y, n);
                end
            end
        end
    end

    // Stage 2: output share s is the XOR of registered cells 3s..3s+2.
    always_comb begin
        f_d = '0;
        g_d = '0;
        h_d = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            for (int s = 0; s < 3; s++) begin
                f_d[3*l + s +: 1] = ^cell_q[27*l + 3*s +: 3];
                g_d[3*l + s +: 1] = ^cell_q[27*l + 9 + 3*s +: 3];
                h_d[3*l + s +: 1] = ^cell_q[27*l + 18 + 3*s +: 3];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            cell_q      <= '0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            g_q         <= '0;
            h_q         <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid_i;
                if (in_valid_i) begin
                    cell_q <= cell_d;
                end
            end
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    f_q <= f_d;
                    g_q <= g_d;
                    h_q <= h_d;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign f_o         = f_q;
    assign g_o         = g_q;
    assign h_o         = h_q;
    assign idle_o      = !s1_valid_q && !out_valid_q;

endmodule

// File: tb/tb_masked_cf_pipe.sv
// tb_masked_cf_pipe: randomised bench for masked_cf_pipe with a 1-lane and a 4-lane
// instance driven in lockstep. Results are checked at the unmasked level (XOR of shares
// against F, G, H of the XOR of input shares), with a queue for ordering.
module tb_masked_cf_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready;
    logic [11:0] a, b, c, d;
    logic [35:0] r1, r2, r3;
    logic [23:0] rs;

    logic        in_ready1, out_valid1, idle1;
    logic [2:0]  f1, g1, h1;
    logic        in_ready4, out_valid4, idle4;
    logic [11:0] f4, g4, h4;

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    logic        acc_d1 = 1'b0, acc_d2 = 1'b0, ordy_d1 = 1'b0, ordy_d2 = 1'b0;
    logic        stall_prev = 1'b0, rst_prev = 1'b0;
    logic [47:0] held = '0;

    masked_cf_pipe #(.LANES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .a_i(a[2:0]), .b_i(b[2:0]), .c_i(c[2:0]), .d_i(d[2:0]),
        .r1_i(r1[8:0]), .r2_i(r2[8:0]), .r3_i(r3[8:0]), .rs_i(rs[5:0]),
        .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .f_o(f1), .g_o(g1), .h_o(h1), .idle_o(idle1)
    );

    masked_cf_pipe #(.LANES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
        .a_i(a), .b_i(b), .c_i(c), .d_i(d),
        .r1_i(r1), .r2_i(r2), .r3_i(r3), .rs_i(rs),
        .out_valid_o(out_valid4), .out_ready_i(out_ready),
        .f_o(f4), .g_o(g4), .h_o(h4), .idle_o(idle4)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unmasked S-box coordinates per lane, packed {H,G,F} at [3l+2:3l].
    function automatic logic [11:0] model(input logic [11:0] av, input logic [11:0] bv,
                                          input logic [11:0] cv, input logic [11:0] dv);
        logic [11:0] res;
        logic        xa, xb, xc, xd;
        for (int l = 0; l < 4; l++) begin
            xa = ^av[3*l +: 3];
            xb = ^bv[3*l +: 3];
            xc = ^cv[3*l +: 3];
            xd = ^dv[3*l +: 3];
            res[3*l +: 3] = {(xb & xd) ^ (xc & xd) ^ xb ^ xa, (xb & xd) ^ xc, xd ^ (xb & xd) ^ xc};
        end
        return res;
    endfunction

    function automatic logic [11:0] fold(input logic [11:0] fv, input logic [11:0] gv,
                                         input logic [11:0] hv);
        logic [11:0] res;
        for (int l = 0; l < 4; l++) begin
            res[3*l +: 3] = {^hv[3*l +: 3], ^gv[3*l +: 3], ^fv[3*l +: 3]};
        end
        return res;
    endfunction

    task automatic rand_inputs();
        a  = 12'($urandom());
        b  = 12'($urandom());
        c  = 12'($urandom());
        d  = 12'($urandom());
        r1 = {4'($urandom()), $urandom()};
        r2 = {4'($urandom()), $urandom()};
        r3 = {4'($urandom()), $urandom()};
        rs = 24'($urandom());
    endtask

    // One clock cycle: observe at edge+1, drive, settle, model the edge, advance.
    task automatic step(input logic vin, input logic ordy, input logic rstv, input logic rnd);
        logic [47:0] now_out;
        logic [11:0] e, o4, o1;
        logic        exp_rdy, xfer, acc;
        now_out = {f4, g4, h4, 9'b0, f1, g1, h1};
        if (rst_prev) begin
            check_eq("rst_out_valid", {out_valid4, out_valid1}, 2'b00);
            check_eq("rst_data", now_out, 48'h0);
            check_eq("rst_idle", {idle4, idle1}, 2'b11);
        end else begin
            if (stall_prev) begin
                check_eq("stall_valid", {out_valid4, out_valid1}, 2'b11);
                check_eq("stall_data", now_out, held);
            end
            if (ordy_d1 && ordy_d2) begin
                check_eq("latency", {out_valid4, out_valid1}, {2{acc_d2}});
            end
            check_eq("idle", {idle4, idle1}, {2{exp_q.size() == 0}});
        end
        rst = rstv;
        in_valid = vin;
        out_ready = ordy;
        if (rnd) rand_inputs();
        #1;
        exp_rdy = !(exp_q.size() == 2 && !ordy);
        check_eq("in_ready", {in_ready4, in_ready1}, {2{exp_rdy}});
        if (rstv) begin
            exp_q.delete();
            acc_d1 = 1'b0;
            acc_d2 = 1'b0;
            ordy_d1 = 1'b1;
            ordy_d2 = 1'b1;
            stall_prev = 1'b0;
        end else begin
            xfer = out_valid1 && ordy;
            acc = vin && exp_rdy;
            if (xfer) begin
                check_eq("out_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    o4 = fold(f4, g4, h4);
                    o1 = fold({9'b0, f1}, {9'b0, g1}, {9'b0, h1});
                    check_eq("out4", o4, e);
                    check_eq("out1", o1[2:0], e[2:0]);
                end
            end
            if (acc) exp_q.push_back(model(a, b, c, d));
            stall_prev = out_valid1 && !ordy;
            held = now_out;
            acc_d2 = acc_d1;
            acc_d1 = acc;
            ordy_d2 = ordy_d1;
            ordy_d1 = ordy;
        end
        rst_prev = rstv;
        @(posedge clk);
        #1;
    endtask

    logic bub [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        rand_inputs();
        @(posedge clk);
        #1;
        rst_prev = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("rdy_after_rst", {in_ready4, in_ready1}, 2'b11);

        // Directed vector with zero randomness.
        a = '0; c = '0; b = 12'h001; d = 12'h001;
        r1 = '0; r2 = '0; r3 = '0; rs = '0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("dir_valid", out_valid1, 1'b1);
        check_eq("dir_f", f1, 3'b000);
        check_eq("dir_g", g1, 3'b100);
        check_eq("dir_h", h1, 3'b110);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

        // Full-rate stream.
        repeat (1000) step(1'b1, 1'b1, 1'b0, 1'b1);

        // Backpressure with random valid and ready.
        repeat (600) step(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

        // Bubbles.
        for (int i = 0; i < 5; i++) step(bub[i], 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

        // Mid-flight reset: both in-flight results dropped, next one lands 2 cycles later.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1);

        check_eq("drain_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
